dpram_stream_reader: RTL and testbench

Read-side master for one port of the 4 KiB × 8 dual-port video/shared RAM. It accepts a (base, length) command, issues back-to-back reads on its RAM port, and delivers the bytes in address order on a valid/ready stream. Typical use: the CPU writes the RAM through port A, and this block drains port B for character scanout or DMA. Reads are credit-limited so no returned byte is ever dropped under output backpressure.

---
 rtl/zed64_mem_pkg.sv | 14 +
 rtl/dpram_stream_reader_if.sv | 32 +++
 rtl/stream_fifo.sv | 67 ++++++
 rtl/dpram_stream_reader.sv | 148 ++++++++++++++
 tb/tb_dpram_stream_reader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/zed64_mem_pkg.sv
// Shared constants and reader FSM state for the zed64 dual-port RAM.
package zed64_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/dpram_stream_reader_if.sv
// RAM read port plus output byte stream of the dual-port RAM reader.
interface dpram_stream_reader_if #(
    parameter int ADDR_W = zed64_mem_pkg::ADDR_W_DEF,
    parameter int DATA_W = zed64_mem_pkg::DATA_W_DEF
);

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wena;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output ram_addr,
        output ram_wena,
        input  ram_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  ram_addr,
        input  ram_wena,
        output ram_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO with a registered head entry and an occupancy count
// that includes the head register.
module stream_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_W-1:0]           din,
    input  logic                        pop,
    output logic [DATA_W-1:0]           dout,
    output logic                        dvalid,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       mem_cnt;
    logic              take;
    logic              mem_rd;
    logic              mem_wr;

    // Head register refills from storage first, else straight from push.
    always_comb begin
        take   = !dvalid || pop;
        mem_rd = take && (mem_cnt != '0);
        mem_wr = push && !(take && (mem_cnt == '0));
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            dvalid  <= 1'b0;
            dout    <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (mem_rd) begin
                dout   <= mem[rd_ptr];
                dvalid <= 1'b1;
                rd_ptr <= rd_ptr + PW'(1);
            end else if (take) begin
                dvalid <= push;
                if (push) begin
                    dout <= din;
                end
            end
            mem_cnt <= mem_cnt + (PW+1)'(mem_wr) - (PW+1)'(mem_rd);
        end
    end

    assign count = mem_cnt + (PW+1)'(dvalid);

endmodule

// File: rtl/dpram_stream_reader.sv
// Credit-limited read master that streams a (base, len) window of the RAM.
// Optional DPRAM_READER_STATS_EN adds a saturating backpressure counter.
module dpram_stream_reader
    import zed64_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
`ifdef DPRAM_READER_STATS_EN
    output logic [15:0]       stall_count,
`endif
    dpram_stream_reader_if.master bus
);

    localparam int OW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = OW + 1;

    rd_state_e         state;
    rd_state_e         state_d;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   iss_cnt;
    logic [ADDR_W:0]   dlv_cnt;
    logic [RD_LAT:0]   vld_sr;
    logic [OW-1:0]     occ;
    logic [OW-1:0]     inflight;
    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;
    logic              credit_ok;
    logic              done_d;

    assign push         = vld_sr[RD_LAT];
    assign pop          = bus.out_valid && bus.out_ready;
    assign busy         = (state != ST_IDLE);
    assign bus.ram_wena = 1'b0;

    // Count every outstanding read as already occupying a FIFO slot.
    assign credit_ok = (CW'(inflight) + CW'(occ)) < CW'(FIFO_DEPTH);

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        issue   = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (iss_cnt == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    issue = credit_ok;
                end
            end
            ST_DRAIN: begin
                if (pop && (dlv_cnt == (ADDR_W+1)'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The first read goes out on the accepting edge so ram_addr=base next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt     <= '0;
            iss_cnt      <= '0;
            dlv_cnt      <= '0;
            vld_sr       <= '0;
            inflight     <= '0;
            done         <= 1'b0;
            bus.ram_addr <= '0;
        end else begin
            done     <= done_d;
            vld_sr   <= {vld_sr[RD_LAT-1:0], issue};
            inflight <= inflight + OW'(issue) - OW'(push);
            if (accept) begin
                dlv_cnt <= len;
            end else if (pop) begin
                dlv_cnt <= dlv_cnt - (ADDR_W+1)'(1);
            end
            if (issue && accept) begin
                bus.ram_addr <= base;
                addr_cnt     <= base + ADDR_W'(1);
                iss_cnt      <= len - (ADDR_W+1)'(1);
            end else if (issue) begin
                bus.ram_addr <= addr_cnt;
                addr_cnt     <= addr_cnt + ADDR_W'(1);
                iss_cnt      <= iss_cnt - (ADDR_W+1)'(1);
            end
        end
    end

`ifdef DPRAM_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            stall_count <= '0;
        end else if (bus.out_valid && !bus.out_ready
                     && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

    stream_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .din    (bus.ram_data),
        .pop    (pop),
        .dout   (bus.out_data),
        .dvalid (bus.out_valid),
        .count  (occ)
    );

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: queue model of expected bytes plus
// directed literal checks of cycle timing.
module tb_dpram_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base = '0;
    logic [12:0] len = '0;
    logic        busy;
    logic        done;
`ifdef DPRAM_READER_STATS_EN
    logic [15:0] stall_count;
`endif

    dpram_stream_reader_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    dpram_stream_reader #(
        .ADDR_W     (12),
        .DATA_W     (8),
        .RD_LAT     (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base        (base),
        .len         (len),
        .busy        (busy),
        .done        (done),
`ifdef DPRAM_READER_STATS_EN
        .stall_count (stall_count),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // RAM with one cycle of read latency.
    logic [7:0] mem [4096];
    always @(posedge clk) bus.ram_data <= mem[bus.ram_addr];

    int   rmode = 0;
    int   rcyc = 0;
    logic rdy_pat = 1'b0;
    logic rdy_force = 1'b0;
    assign bus.out_ready = (rmode == 0) ? 1'b1 :
                           (rmode == 1) ? rdy_pat : rdy_force;

    always @(posedge clk) begin
        #1;
        rcyc++;
        rdy_pat = ((rcyc % 3) == 0);
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         active = 0;
    bit         done_due = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;
    logic [7:0] t1 [4];
    logic [7:0] t2 [4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_cmd(input logic [11:0] b, input int l);
        logic [11:0] a;
        for (int i = 0; i < l; i++) begin
            a = b + 12'(i);
            exp_q.push_back(mem[a]);
        end
        if (l == 0) done_due = 1;
        else active = 1;
    endtask

    task automatic send(input logic [11:0] b, input int l);
        @(posedge clk); #1;
        start = 1'b1;
        base  = b;
        len   = 13'(l);
        @(posedge clk); #1;
        start = 1'b0;
        model_cmd(b, l);
    endtask

    task automatic wait_cmd(input int max);
        int n = 0;
        while ((active || exp_q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_timeout", 32'(active), 32'(0));
        @(negedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            active     = 0;
            done_due   = 0;
            prev_stall = 0;
        end else begin
            chk("ram_wena", 32'(bus.ram_wena), 32'(0));
            chk("busy", 32'(busy), 32'(active));
            chk("done", 32'(done), 32'(done_due));
            done_due = 0;
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.out_valid), 32'(1));
                chk("hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (!active) chk("idle_valid", 32'(bus.out_valid), 32'(0));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(1), 32'(0));
                end else begin
                    chk("stream_data", 32'(bus.out_data),
                        32'(exp_q.pop_front()));
                    if (exp_q.size() == 0) begin
                        active   = 0;
                        done_due = 1;
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        int n;
        int got;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 5);
        t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        t2 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_data", 32'(bus.out_data), 32'(0));
        chk("rst_addr", 32'(bus.ram_addr), 32'(0));
        chk("rst_wena", 32'(bus.ram_wena), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic timing with literal data.
        for (int i = 0; i < 4; i++) mem[12'h010 + 12'(i)] = t1[i];
        send(12'h010, 4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                chk("t1_valid", 32'(bus.out_valid), 32'(1));
                chk("t1_data", 32'(bus.out_data), 32'(t1[c-3]));
            end
            chk("t1_done", 32'(done), 32'(c == 7));
            chk("t1_busy", 32'(busy), 32'(c >= 1 && c <= 6));
        end

        // Address wrap at the top of the RAM.
        mem[12'hFFE] = t2[0];
        mem[12'hFFF] = t2[1];
        mem[12'h000] = t2[2];
        mem[12'h001] = t2[3];
        send(12'hFFE, 4);
        got = 0;
        n = 0;
        while (got < 4 && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.out_valid && bus.out_ready) begin
                chk("t2_byte", 32'(bus.out_data), 32'(t2[got]));
                got++;
            end
        end
        chk("t2_count", 32'(got), 32'(4));
        wait_cmd(20);

        // Heavy backpressure: ready one cycle in three.
        rmode = 1;
        send(12'h100, 16);
        wait_cmd(300);
        chk("t3_drained", 32'(exp_q.size()), 32'(0));
        rmode = 0;

        // Zero length: done next cycle, address untouched.
        send(12'h555, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t4_done", 32'(done), 32'(c == 1));
            chk("t4_addr", 32'(bus.ram_addr), 32'(12'h10F));
            chk("t4_valid", 32'(bus.out_valid), 32'(0));
        end

        // Reset in the middle of a command.
        send(12'h200, 10);
        got = 0;
        n = 0;
        while (got < 5 && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.out_valid && bus.out_ready) got++;
        end
        chk("t5_count", 32'(got), 32'(5));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_valid", 32'(bus.out_valid), 32'(0));
        chk("t5_done", 32'(done), 32'(0));
        repeat (3) begin
            @(negedge clk);
            chk("t5_nodone", 32'(done), 32'(0));
        end
        send(12'h300, 6);
        wait_cmd(40);
        chk("t5_drained", 32'(exp_q.size()), 32'(0));

`ifdef DPRAM_READER_STATS_EN
        rdy_force = 1'b0;
        rmode = 2;
        send(12'h020, 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        rdy_force = 1'b1;
        wait_cmd(20);
        chk("stall_count", 32'(stall_count), 32'(7));
        rmode = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
